// File: rtl/c_rst_pkg.sv
// Shared definitions for the reset supervisor: FSM state encoding and
// bit positions inside the sticky reset-cause register.
package c_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int CS_POR   = 0;
    localparam int CS_MR    = 1;
    localparam int CS_SENSE = 2;
    localparam int CS_WDT   = 3;

endpackage

// File: rtl/c_rst_filt.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised input after N consecutive differing samples.
module c_rst_filt #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(N + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Counter only runs while the synced level disagrees with the output;
    // any agreeing sample restarts the qualification window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(N - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/c_rst_sup.sv
// Reset supervisor: filters manual-reset, supply-sense and watchdog inputs,
// drives a held active-low system reset and records a sticky reset cause.
module c_rst_sup
    import c_rst_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int HOLD = 3000,
    parameter int DEB  = 16,
    parameter int SFLT = 4,
    parameter int WDT  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mr_n,
    input  logic [NCH-1:0] sense,
    input  logic [NCH-1:0] ch_en,
    input  logic           wdi,
    input  logic           cause_clr,
    output logic           rst_n,
    output logic [3:0]     cause,
    output logic [NCH-1:0] sense_ok
);

    localparam int HW = $clog2(HOLD + 1);

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic          mr_f;
    logic          mr_fault;
    logic          sense_fault;
    logic          wdt_exp;
    logic          fault;
    logic          por_phase;
    logic [3:0]    cause_set;

    c_rst_filt #(.N(DEB)) u_mr_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (mr_n),
        .dout (mr_f)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_sense
        c_rst_filt #(.N(SFLT)) u_sense_filt (
            .clk  (clk),
            .rst  (rst),
            .din  (sense[i]),
            .dout (sense_ok[i])
        );
    end

    if (WDT > 0) begin : g_wdt
        localparam int WW = $clog2(WDT + 1);

        logic [2:0]    wdi_sync;
        logic [WW-1:0] wdt_cnt;
        logic          kick;

        assign kick    = wdi_sync[1] & ~wdi_sync[2];
        assign wdt_exp = (state == ST_RUN) && (wdt_cnt == WW'(WDT - 1)) && !kick;

        // Counter is pinned at zero outside RUN so it restarts on every entry;
        // it saturates at the expiry value rather than wrapping.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wdi_sync <= 3'b000;
                wdt_cnt  <= '0;
            end else begin
                wdi_sync <= {wdi_sync[1:0], wdi};
                if (state != ST_RUN || kick) begin
                    wdt_cnt <= '0;
                end else if (wdt_cnt != WW'(WDT - 1)) begin
                    wdt_cnt <= wdt_cnt + WW'(1);
                end
            end
        end
    end else begin : g_no_wdt
        logic wdi_unused;
        assign wdi_unused = wdi;
        assign wdt_exp    = 1'b0;
    end

    assign mr_fault    = ~mr_f;
    assign sense_fault = |(ch_en & ~sense_ok);
    assign fault       = mr_fault | sense_fault | wdt_exp;

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        case (state)
            ST_ASSERT: begin
                if (!fault) begin
                    state_nx = ST_HOLD;
                    hold_nx  = '0;
                end
            end
            ST_HOLD: begin
                if (fault) begin
                    state_nx = ST_ASSERT;
                    hold_nx  = '0;
                end else if (hold_cnt == HW'(HOLD - 1)) begin
                    state_nx = ST_RUN;
                    hold_nx  = '0;
                end else begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end
            ST_RUN: begin
                if (fault) begin
                    state_nx = ST_ASSERT;
                end
            end
            default: begin
                state_nx = ST_ASSERT;
                hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ASSERT;
            hold_cnt <= '0;
            rst_n    <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            rst_n    <= (state_nx == ST_RUN);
        end
    end

    // Until the first release the filters still sit at their reset value,
    // so power-on is attributed to POR alone rather than to MR/SENSE.
    always_comb begin
        cause_set           = 4'b0000;
        cause_set[CS_MR]    = mr_fault;
        cause_set[CS_SENSE] = sense_fault;
        cause_set[CS_WDT]   = wdt_exp;
        if (por_phase) begin
            cause_set = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause     <= 4'b0001 << CS_POR;
            por_phase <= 1'b1;
        end else begin
            cause <= (cause_clr ? 4'b0000 : cause) | cause_set;
            if (state == ST_ASSERT && state_nx == ST_HOLD) begin
                por_phase <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c_rst_sup.sv
// Directed testbench for c_rst_sup: a vector table for steady-state sense
// masking plus hand-timed sequences for latency, watchdog and reset cases.
module tb_c_rst_sup;

    localparam int NCH  = 2;
    localparam int HOLD = 10;
    localparam int DEB  = 4;
    localparam int SFLT = 2;
    localparam int WDT  = 20;

    typedef struct {
        logic [1:0] sense;
        logic [1:0] ch_en;
        logic [1:0] exp_ok;
        logic       exp_rst_n;
        logic [3:0] exp_cause;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           mr_n;
    logic [NCH-1:0] sense;
    logic [NCH-1:0] ch_en;
    logic           wdi;
    logic           cause_clr;
    logic           rst_n;
    logic [3:0]     cause;
    logic [NCH-1:0] sense_ok;

    logic           kick_en;
    logic           man_wdi;
    logic           auto_wdi;
    logic [2:0]     kick_ph;

    logic           w0_rst_n;
    logic [3:0]     w0_cause_unused;
    logic [NCH-1:0] w0_sense_ok_unused;
    logic           w0_watch;
    int             w0_drops;

    int             vec_cnt;
    int             err_cnt;
    vec_t           vecs[8];

    c_rst_sup #(
        .NCH (NCH), .HOLD (HOLD), .DEB (DEB), .SFLT (SFLT), .WDT (WDT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mr_n      (mr_n),
        .sense     (sense),
        .ch_en     (ch_en),
        .wdi       (wdi),
        .cause_clr (cause_clr),
        .rst_n     (rst_n),
        .cause     (cause),
        .sense_ok  (sense_ok)
    );

    c_rst_sup #(
        .NCH (NCH), .HOLD (HOLD), .DEB (DEB), .SFLT (SFLT), .WDT (0)
    ) u_dut_nowdt (
        .clk       (clk),
        .rst       (rst),
        .mr_n      (1'b1),
        .sense     (2'b11),
        .ch_en     (2'b11),
        .wdi       (1'b0),
        .cause_clr (1'b0),
        .rst_n     (w0_rst_n),
        .cause     (w0_cause_unused),
        .sense_ok  (w0_sense_ok_unused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign wdi = kick_en ? auto_wdi : man_wdi;

    // Background kicker keeps the watchdog quiet outside the watchdog test.
    initial begin
        auto_wdi = 1'b0;
        kick_ph  = 3'd0;
        forever begin
            @(negedge clk);
            kick_ph  = kick_ph + 3'd1;
            auto_wdi = kick_ph[2];
        end
    end

    always @(posedge clk) begin
        if (w0_watch && !w0_rst_n) begin
            w0_drops <= w0_drops + 1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: run exceeded its time budget");
        $fatal(1, "[TB] time budget exhausted");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sense = v.sense;
        ch_en = v.ch_en;
    endtask

    task automatic clearCause();
        cause_clr = 1'b1;
        step(1);
        cause_clr = 1'b0;
    endtask

    task automatic waitRun(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rst_n) break;
            @(negedge clk);
        end
        checkOutput(name, 32'(rst_n), 32'd1);
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        w0_watch  = 1'b0;
        w0_drops  = 0;
        rst       = 1'b1;
        mr_n      = 1'b1;
        sense     = 2'b11;
        ch_en     = 2'b11;
        cause_clr = 1'b0;
        kick_en   = 1'b1;
        man_wdi   = 1'b0;

        vecs[0] = '{2'b11, 2'b11, 2'b11, 1'b1, 4'b0000};
        vecs[1] = '{2'b10, 2'b10, 2'b10, 1'b1, 4'b0000};
        vecs[2] = '{2'b00, 2'b00, 2'b00, 1'b1, 4'b0000};
        vecs[3] = '{2'b01, 2'b00, 2'b01, 1'b1, 4'b0000};
        vecs[4] = '{2'b01, 2'b01, 2'b01, 1'b1, 4'b0000};
        vecs[5] = '{2'b11, 2'b01, 2'b11, 1'b1, 4'b0000};
        vecs[6] = '{2'b11, 2'b11, 2'b11, 1'b1, 4'b0000};
        vecs[7] = '{2'b01, 2'b11, 2'b01, 1'b0, 4'b0100};

        $display("[TB] power-up");
        step(3);
        checkOutput("rst_rst_n", 32'(rst_n), 32'd0);
        checkOutput("rst_cause", 32'(cause), 32'h1);
        checkOutput("rst_sense_ok", 32'(sense_ok), 32'h0);
        rst = 1'b0;
        step(16);
        checkOutput("pu_rst_n_e16", 32'(rst_n), 32'd0);
        step(1);
        checkOutput("pu_rst_n_e17", 32'(rst_n), 32'd1);
        checkOutput("pu_cause", 32'(cause), 32'h1);
        checkOutput("pu_sense_ok", 32'(sense_ok), 32'h3);

        $display("[TB] manual reset");
        mr_n = 1'b0;
        step(3);
        mr_n = 1'b1;
        step(15);
        checkOutput("mr_short_rst_n", 32'(rst_n), 32'd1);
        mr_n = 1'b0;
        step(6);
        checkOutput("mr_e6_rst_n", 32'(rst_n), 32'd1);
        mr_n = 1'b1;
        step(1);
        checkOutput("mr_e7_rst_n", 32'(rst_n), 32'd0);
        checkOutput("mr_cause", 32'(cause), 32'h3);
        step(15);
        checkOutput("mr_e22_rst_n", 32'(rst_n), 32'd0);
        step(1);
        checkOutput("mr_e23_rst_n", 32'(rst_n), 32'd1);

        $display("[TB] clear versus set");
        mr_n = 1'b0;
        step(6);
        mr_n      = 1'b1;
        cause_clr = 1'b1;
        step(1);
        cause_clr = 1'b0;
        checkOutput("clr_mr_rst_n", 32'(rst_n), 32'd0);
        checkOutput("clr_mr_cause", 32'(cause), 32'h2);
        waitRun("clr_mr_release", 40);
        clearCause();
        checkOutput("clr_cause", 32'(cause), 32'h0);

        $display("[TB] sense vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            step(8);
            checkOutput($sformatf("vec%0d_sense_ok", i), 32'(sense_ok), 32'(vecs[i].exp_ok));
            checkOutput($sformatf("vec%0d_rst_n", i), 32'(rst_n), 32'(vecs[i].exp_rst_n));
            checkOutput($sformatf("vec%0d_cause", i), 32'(cause), 32'(vecs[i].exp_cause));
        end
        sense = 2'b11;
        ch_en = 2'b11;
        waitRun("vec_release", 40);

        $display("[TB] channel enable");
        clearCause();
        sense = 2'b01;
        ch_en = 2'b01;
        step(8);
        checkOutput("en_masked_ok", 32'(sense_ok), 32'h1);
        checkOutput("en_masked_rst_n", 32'(rst_n), 32'd1);
        ch_en = 2'b11;
        step(1);
        checkOutput("en_unmask_rst_n", 32'(rst_n), 32'd0);
        checkOutput("en_unmask_cause", 32'(cause), 32'h4);
        sense = 2'b11;
        waitRun("en_release", 40);

        $display("[TB] watchdog");
        clearCause();
        checkOutput("wdt_pre_cause", 32'(cause), 32'h0);
        man_wdi  = 1'b0;
        kick_en  = 1'b0;
        w0_watch = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            man_wdi = (c % 15 == 0);
        end
        checkOutput("wdt_kicked_rst_n", 32'(rst_n), 32'd1);
        @(negedge clk);
        man_wdi = 1'b1;
        step(1);
        man_wdi = 1'b0;
        step(21);
        checkOutput("wdt_e22_rst_n", 32'(rst_n), 32'd1);
        step(1);
        checkOutput("wdt_e23_rst_n", 32'(rst_n), 32'd0);
        checkOutput("wdt_cause", 32'(cause), 32'h8);
        checkOutput("nowdt_drops", 32'(w0_drops), 32'd0);
        checkOutput("nowdt_rst_n", 32'(w0_rst_n), 32'd1);
        w0_watch = 1'b0;
        kick_en  = 1'b1;
        step(10);
        checkOutput("wdt_rel_e33", 32'(rst_n), 32'd0);
        step(1);
        checkOutput("wdt_rel_e34", 32'(rst_n), 32'd1);

        $display("[TB] async reset in RUN and HOLD");
        step(2);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_run_rst_n", 32'(rst_n), 32'd0);
        checkOutput("rst_run_cause", 32'(cause), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        step(10);
        checkOutput("hold_pre_ok", 32'(sense_ok), 32'h3);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_hold_ok", 32'(sense_ok), 32'h0);
        checkOutput("rst_hold_cause", 32'(cause), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] sense glitch during HOLD");
        step(10);
        sense = 2'b10;
        step(3);
        sense = 2'b11;
        step(1);
        checkOutput("glitch_e14_cause", 32'(cause), 32'h1);
        step(1);
        checkOutput("glitch_e15_cause", 32'(cause), 32'h5);
        step(12);
        checkOutput("glitch_e27_rst_n", 32'(rst_n), 32'd0);
        step(1);
        checkOutput("glitch_e28_rst_n", 32'(rst_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
